// File: rtl/rf_pkg.sv
// Shared constants and FSM state type for the pipelined register file
// with scoreboard and sequential clear.
package rf_pkg;

  localparam int RF_A_WIDTH  = 5;
  localparam int RF_D_WIDTH  = 32;
  localparam int RF_TRIG_REG = 9;
  localparam int RF_A0_REG   = 10;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } rf_state_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-producer scoreboard: one bit per register, set on issue, cleared on
// committed writeback, flushed as a whole. Entry 0 is never pending.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int A_WIDTH = RF_A_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               set_en,
  input  logic [A_WIDTH-1:0] set_idx,
  input  logic               clr_en,
  input  logic [A_WIDTH-1:0] clr_idx,
  input  logic [A_WIDTH-1:0] ad1,
  input  logic [A_WIDTH-1:0] ad2,
  output logic               pend1,
  output logic               pend2
);

  localparam int DEPTH = 2 ** A_WIDTH;

  logic [DEPTH-1:0] pending_r;
  logic [DEPTH-1:0] pending_next_s;

  // Next pending vector: flush beats everything, set beats a same-entry clear.
  always_comb begin
    pending_next_s    = pending_r;
    pending_next_s[0] = 1'b0;
    for (int i = 1; i < DEPTH; i++) begin
      if (flush) begin
        pending_next_s[i] = 1'b0;
      end else if (set_en && (set_idx == A_WIDTH'(i))) begin
        pending_next_s[i] = 1'b1;
      end else if (clr_en && (clr_idx == A_WIDTH'(i))) begin
        pending_next_s[i] = 1'b0;
      end else begin
        pending_next_s[i] = pending_r[i];
      end
    end
  end

  // Pending vector state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_r <= {DEPTH{1'b0}};
    end else begin
      pending_r <= pending_next_s;
    end
  end

  // Lookups see only the stored vector, never a same-cycle clear.
  assign pend1 = pending_r[ad1];
  assign pend2 = pending_r[ad2];

endmodule

// File: rtl/rf_pipe.sv
// Register file with write-through read bypass, trigger register, a0 mirror,
// issue scoreboard and a one-register-per-cycle clear sequence.
module rf_pipe
  import rf_pkg::*;
#(
  parameter int A_WIDTH  = RF_A_WIDTH,
  parameter int D_WIDTH  = RF_D_WIDTH,
  parameter int TRIG_REG = RF_TRIG_REG,
  parameter int A0_REG   = RF_A0_REG
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we3,
  input  logic [A_WIDTH-1:0] ad3,
  input  logic [D_WIDTH-1:0] wd3,
  input  logic [A_WIDTH-1:0] ad1,
  input  logic [A_WIDTH-1:0] ad2,
  output logic [D_WIDTH-1:0] rd1,
  output logic [D_WIDTH-1:0] rd2,
  input  logic               issue_v,
  input  logic [A_WIDTH-1:0] issue_rd,
  output logic               pend1,
  output logic               pend2,
  input  logic               trigger,
  input  logic               clr_req,
  output logic               clr_busy,
  output logic [D_WIDTH-1:0] a0
);

  localparam int                 DEPTH     = 2 ** A_WIDTH;
  localparam logic [A_WIDTH-1:0] IDX_ZERO  = {A_WIDTH{1'b0}};
  localparam logic [A_WIDTH-1:0] IDX_ONE   = {{(A_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [A_WIDTH-1:0] IDX_LAST  = {A_WIDTH{1'b1}};
  localparam logic [A_WIDTH-1:0] TRIG_IDX  = A_WIDTH'(TRIG_REG);
  localparam logic [D_WIDTH-1:0] DATA_ZERO = {D_WIDTH{1'b0}};
  localparam logic [D_WIDTH-1:0] DATA_ONE  = {{(D_WIDTH-1){1'b0}}, 1'b1};

  rf_state_t          state_r;
  rf_state_t          state_next_s;
  logic [A_WIDTH-1:0] clr_idx_r;
  logic [D_WIDTH-1:0] regs_r [DEPTH];

  logic idle_s;
  logic wr_en_s;
  logic trig_en_s;
  logic start_clr_s;

  // Qualified strobes: nothing architectural happens while clearing.
  always_comb begin
    idle_s      = (state_r == ST_IDLE);
    wr_en_s     = idle_s && we3 && (ad3 != IDX_ZERO);
    trig_en_s   = idle_s && trigger && !(wr_en_s && (ad3 == TRIG_IDX));
    start_clr_s = idle_s && clr_req;
  end

  // Clear FSM next state and busy flag.
  always_comb begin
    state_next_s = state_r;
    clr_busy     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        clr_busy = 1'b0;
        if (clr_req) begin
          state_next_s = ST_CLEAR;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        clr_busy = 1'b1;
        if (clr_idx_r == IDX_LAST) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_CLEAR;
        end
      end
      default: begin
        clr_busy     = 1'b0;
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Clear FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Clear index starts at 1 and saturates at the terminal entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_idx_r <= IDX_ZERO;
    end else if (start_clr_s) begin
      clr_idx_r <= IDX_ONE;
    end else if ((state_r == ST_CLEAR) && (clr_idx_r != IDX_LAST)) begin
      clr_idx_r <= clr_idx_r + IDX_ONE;
    end else begin
      clr_idx_r <= clr_idx_r;
    end
  end

  // Register array: writeback and trigger in IDLE, one zeroing per cycle in CLEAR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_r[i] <= DATA_ZERO;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (trig_en_s) begin
            regs_r[TRIG_REG] <= DATA_ONE;
          end
          if (wr_en_s) begin
            regs_r[ad3] <= wd3;
          end
        end
        ST_CLEAR: begin
          regs_r[clr_idx_r] <= DATA_ZERO;
        end
        default: begin
          regs_r[0] <= DATA_ZERO;
        end
      endcase
    end
  end

  // Read ports with write-through bypass; entry 0 is hardwired to zero.
  always_comb begin
    rd1 = DATA_ZERO;
    rd2 = DATA_ZERO;
    if (ad1 == IDX_ZERO) begin
      rd1 = DATA_ZERO;
    end else if (wr_en_s && (ad3 == ad1)) begin
      rd1 = wd3;
    end else begin
      rd1 = regs_r[ad1];
    end
    if (ad2 == IDX_ZERO) begin
      rd2 = DATA_ZERO;
    end else if (wr_en_s && (ad3 == ad2)) begin
      rd2 = wd3;
    end else begin
      rd2 = regs_r[ad2];
    end
  end

  assign a0 = regs_r[A0_REG];

  rf_scoreboard #(
    .A_WIDTH (A_WIDTH)
  ) u_scoreboard (
    .clk     (clk),
    .rst     (rst),
    .flush   (start_clr_s),
    .set_en  (idle_s && issue_v),
    .set_idx (issue_rd),
    .clr_en  (wr_en_s),
    .clr_idx (ad3),
    .ad1     (ad1),
    .ad2     (ad2),
    .pend1   (pend1),
    .pend2   (pend2)
  );

endmodule

// File: tb/tb_rf_pipe.sv
// Directed bench for rf_pipe: stimulus queues expected values, a negedge
// monitor pops and compares them against the live outputs.
module tb_rf_pipe;

  localparam int AW = 5;
  localparam int DW = 32;

  localparam int K_RD1   = 0;
  localparam int K_RD2   = 1;
  localparam int K_PEND1 = 2;
  localparam int K_PEND2 = 3;
  localparam int K_BUSY  = 4;
  localparam int K_A0    = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          we3;
  logic [AW-1:0] ad3;
  logic [DW-1:0] wd3;
  logic [AW-1:0] ad1;
  logic [AW-1:0] ad2;
  logic [DW-1:0] rd1;
  logic [DW-1:0] rd2;
  logic          issue_v;
  logic [AW-1:0] issue_rd;
  logic          pend1;
  logic          pend2;
  logic          trigger;
  logic          clr_req;
  logic          clr_busy;
  logic [DW-1:0] a0;

  always #5 clk = ~clk;

  rf_pipe #(
    .A_WIDTH  (AW),
    .D_WIDTH  (DW),
    .TRIG_REG (9),
    .A0_REG   (10)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .we3      (we3),
    .ad3      (ad3),
    .wd3      (wd3),
    .ad1      (ad1),
    .ad2      (ad2),
    .rd1      (rd1),
    .rd2      (rd2),
    .issue_v  (issue_v),
    .issue_rd (issue_rd),
    .pend1    (pend1),
    .pend2    (pend2),
    .trigger  (trigger),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .a0       (a0)
  );

  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  exp_t        mon_e;
  logic [31:0] mon_act;

  function automatic logic [31:0] actual(input int kind);
    case (kind)
      K_RD1:   return rd1;
      K_RD2:   return rd2;
      K_PEND1: return {31'd0, pend1};
      K_PEND2: return {31'd0, pend2};
      K_BUSY:  return {31'd0, clr_busy};
      K_A0:    return a0;
      default: return 32'hxxxx_xxxx;
    endcase
  endfunction

  // Monitor: everything queued during a cycle is compared at its falling edge.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      mon_e   = q.pop_front();
      mon_act = actual(mon_e.kind);
      checks++;
      if (mon_act !== mon_e.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h at %0t", mon_e.name, mon_act, mon_e.exp, $time);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input int kind, input logic [31:0] v, input string name);
    exp_t e;
    e.kind = kind;
    e.exp  = v;
    e.name = name;
    q.push_back(e);
  endtask

  task automatic quiet();
    we3      = 1'b0;
    ad3      = 5'd0;
    wd3      = 32'd0;
    issue_v  = 1'b0;
    issue_rd = 5'd0;
    trigger  = 1'b0;
    clr_req  = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    quiet();
    ad1 = 5'd5;
    ad2 = 5'd10;
    tick();
    // Reset state
    expect_val(K_RD1, 32'd0, "reset_rd1");
    expect_val(K_RD2, 32'd0, "reset_rd2");
    expect_val(K_A0, 32'd0, "reset_a0");
    expect_val(K_PEND1, 32'd0, "reset_pend1");
    expect_val(K_BUSY, 32'd0, "reset_busy");
    tick();
    rst = 1'b0;
    tick();

    // Write-through bypass on both ports
    quiet(); we3 = 1'b1; ad3 = 5'd5; wd3 = 32'hDEAD_BEEF; ad1 = 5'd5; ad2 = 5'd5;
    expect_val(K_RD1, 32'hDEAD_BEEF, "bypass_rd1");
    expect_val(K_RD2, 32'hDEAD_BEEF, "bypass_rd2");
    tick();
    quiet();
    expect_val(K_RD1, 32'hDEAD_BEEF, "x5_after_write");
    tick();

    // Register 0 ignores writes
    quiet(); we3 = 1'b1; ad3 = 5'd0; wd3 = 32'h0000_1234; ad1 = 5'd0; ad2 = 5'd0;
    expect_val(K_RD1, 32'd0, "x0_write_cycle_rd1");
    expect_val(K_RD2, 32'd0, "x0_write_cycle_rd2");
    tick();
    quiet();
    expect_val(K_RD1, 32'd0, "x0_after_write");
    tick();

    // Scoreboard set/clear ordering
    quiet(); issue_v = 1'b1; issue_rd = 5'd7; ad1 = 5'd7;
    expect_val(K_PEND1, 32'd0, "pend_no_bypass");
    tick();
    quiet(); issue_v = 1'b1; issue_rd = 5'd7; we3 = 1'b1; ad3 = 5'd7; wd3 = 32'h0000_0077;
    expect_val(K_PEND1, 32'd1, "pend_after_issue");
    expect_val(K_RD1, 32'h0000_0077, "x7_bypass");
    tick();
    quiet(); we3 = 1'b1; ad3 = 5'd7; wd3 = 32'h0000_0078;
    expect_val(K_PEND1, 32'd1, "pend_set_wins");
    tick();
    quiet();
    expect_val(K_PEND1, 32'd0, "pend_cleared");
    expect_val(K_RD1, 32'h0000_0078, "x7_value");
    tick();
    quiet(); issue_v = 1'b1; issue_rd = 5'd0; ad2 = 5'd0;
    tick();
    quiet();
    expect_val(K_PEND2, 32'd0, "pend_x0_never");
    tick();

    // Trigger register
    quiet(); trigger = 1'b1; we3 = 1'b1; ad3 = 5'd9; wd3 = 32'h0000_0055; ad1 = 5'd9;
    expect_val(K_RD1, 32'h0000_0055, "trig_we_bypass");
    tick();
    quiet(); trigger = 1'b1;
    expect_val(K_RD1, 32'h0000_0055, "trig_write_wins");
    tick();
    quiet();
    expect_val(K_RD1, 32'd1, "trig_alone");
    tick();

    // a0 mirror has no bypass
    quiet(); we3 = 1'b1; ad3 = 5'd10; wd3 = 32'hA0A0_0001;
    expect_val(K_A0, 32'd0, "a0_no_bypass");
    tick();
    quiet();
    expect_val(K_A0, 32'hA0A0_0001, "a0_after_write");
    tick();

    // Full clear sequence with ignored traffic
    for (int i = 1; i < 32; i++) begin
      quiet(); we3 = 1'b1; ad3 = AW'(i); wd3 = 32'h1000_0000 + 32'(i);
      tick();
    end
    quiet(); issue_v = 1'b1; issue_rd = 5'd3;
    tick();
    quiet(); clr_req = 1'b1; ad1 = 5'd20; ad2 = 5'd3;
    expect_val(K_BUSY, 32'd0, "busy_req_cycle");
    expect_val(K_PEND2, 32'd1, "pend_before_flush");
    tick();
    for (int k = 1; k < 32; k++) begin
      quiet(); we3 = 1'b1; ad3 = 5'd5; wd3 = 32'hCAFE_0000 | 32'(k);
      issue_v = 1'b1; issue_rd = 5'd12; trigger = 1'b1; clr_req = 1'b1;
      ad1 = 5'd20; ad2 = 5'd12;
      expect_val(K_BUSY, 32'd1, "busy_clear");
      expect_val(K_RD1, (k <= 20) ? 32'h1000_0014 : 32'd0, "x20_during_clear");
      expect_val(K_PEND2, 32'd0, "pend_during_clear");
      tick();
    end
    quiet();
    expect_val(K_BUSY, 32'd0, "busy_done");
    expect_val(K_A0, 32'd0, "a0_after_clear");
    tick();
    for (int i = 1; i < 32; i++) begin
      quiet(); ad1 = AW'(i); ad2 = 5'd12;
      expect_val(K_RD1, 32'd0, "reg_after_clear");
      expect_val(K_PEND2, 32'd0, "pend_after_clear");
      tick();
    end
    quiet(); we3 = 1'b1; ad3 = 5'd6; wd3 = 32'h0000_0066;
    tick();
    quiet(); ad1 = 5'd6;
    expect_val(K_RD1, 32'h0000_0066, "write_after_clear");
    tick();

    // Reset aborting a clear at cycle 10
    quiet(); we3 = 1'b1; ad3 = 5'd31; wd3 = 32'hFFFF_0000;
    tick();
    quiet(); we3 = 1'b1; ad3 = 5'd10; wd3 = 32'hA5A5_A5A5;
    tick();
    quiet(); issue_v = 1'b1; issue_rd = 5'd4;
    tick();
    quiet(); clr_req = 1'b1;
    tick();
    quiet(); ad1 = 5'd31; ad2 = 5'd4;
    for (int k = 1; k < 9; k++) tick();
    expect_val(K_A0, 32'hA5A5_A5A5, "a0_cycle9");
    expect_val(K_RD1, 32'hFFFF_0000, "x31_cycle9");
    expect_val(K_BUSY, 32'd1, "busy_cycle9");
    tick();
    rst = 1'b1;
    expect_val(K_BUSY, 32'd0, "abort_busy");
    expect_val(K_RD1, 32'd0, "abort_x31");
    expect_val(K_A0, 32'd0, "abort_a0");
    expect_val(K_PEND2, 32'd0, "abort_pend");
    tick();
    rst = 1'b0;
    expect_val(K_BUSY, 32'd0, "post_abort_busy");
    expect_val(K_RD1, 32'd0, "post_abort_x31");
    tick();
    quiet(); we3 = 1'b1; ad3 = 5'd10; wd3 = 32'h1234_5678;
    tick();
    quiet();
    expect_val(K_A0, 32'h1234_5678, "a0_after_abort");
    tick();
    tick();

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d pending entries expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_pipe.md
RF_PIPE -- requirements
Module: rf_pipe

Interface
REQ-001 Parameter A_WIDTH, default 5, register address width; depth is 2**A_WIDTH.
REQ-002 Parameter D_WIDTH, default 32, register data width.
REQ-003 Parameter TRIG_REG, default 9, register index set to 1 by trigger.
REQ-004 Parameter A0_REG, default 10, register index mirrored on a0.
REQ-005 clk  in  1  sole clock, all state updates on rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 we3, ad3, wd3  in  1/A_WIDTH/D_WIDTH  writeback enable, address, data.
REQ-008 ad1, ad2  in  A_WIDTH  read addresses; rd1, rd2  out  D_WIDTH  read data.
REQ-009 issue_v, issue_rd  in  1/A_WIDTH  instruction issue: mark issue_rd as pending producer.
REQ-010 pend1, pend2  out  1  scoreboard pending bit for ad1, ad2.
REQ-011 trigger  in  1  set register TRIG_REG to 1.
REQ-012 clr_req  in  1  request sequential clear of all registers.
REQ-013 clr_busy  out  1  clear sequence in progress.
REQ-014 a0  out  D_WIDTH  contents of register A0_REG.

Function
REQ-015 Register 0 SHALL always read 0, never be written, never be pending.
REQ-016 Writes SHALL commit on the rising edge when we3=1, ad3!=0, clr_busy=0.
REQ-017 Reads SHALL be combinational; if we3=1, ad3==adN, ad3!=0, clr_busy=0, rdN SHALL return wd3 (write-through bypass).
REQ-018 a0 SHALL reflect the registered array value (no bypass).
REQ-019 trigger=1 SHALL write 1 to TRIG_REG on the edge; a same-cycle we3 to TRIG_REG SHALL win.
REQ-020 Scoreboard: issue_v sets pending[issue_rd], committed write clears pending[ad3]; same register same cycle -> set wins.
REQ-021 pendN SHALL be combinational from scoreboard, ignoring a same-cycle clear (no bypass on pending).
REQ-022 FSM states IDLE, CLEAR; IDLE->CLEAR on clr_req; CLEAR->IDLE after index 2**A_WIDTH-1 is zeroed.
REQ-023 On IDLE->CLEAR edge the whole scoreboard SHALL be zeroed and the clear index set to 1.
REQ-024 In CLEAR one register per cycle SHALL be zeroed, index incrementing; clear takes 2**A_WIDTH-1 cycles.
REQ-025 In CLEAR, we3, issue_v, trigger and clr_req SHALL be ignored; clr_busy=1 exactly while in CLEAR.
REQ-026 Index counter SHALL be A_WIDTH bits; terminal detect on all-ones, no wrap into register 0.

Reset
REQ-027 rst SHALL immediately zero all registers, scoreboard, clear index, and force IDLE.
REQ-028 During and after reset: rd1/rd2/a0 = 0, pend1/pend2 = 0, clr_busy = 0.
REQ-029 rst asserted mid-CLEAR SHALL abort the sequence with the above values.

Structure
REQ-030 Package rf_pkg SHALL hold the FSM state enum and default A_WIDTH, D_WIDTH, TRIG_REG, A0_REG constants.
REQ-031 Scoreboard SHALL be sub-module rf_scoreboard (pending vector, set/clear, two lookup ports, flush input).
REQ-032 Array, bypass, trigger and clear FSM SHALL reside in rf_pipe.

Verification
REQ-033 Write x5=0xDEADBEEF, same cycle ad1=5 -> rd1=0xDEADBEEF combinationally; next cycle rd1 unchanged.
REQ-034 Write x0=0x1234 with ad1=0 -> rd1=0 in write cycle and after.
REQ-035 issue x7, then write x7 while issue x7 -> pend1 (ad1=7) stays 1; write x7 alone next -> pend1=0.
REQ-036 trigger plus we3 to x9 with 0x55 same cycle -> x9=0x55; trigger alone -> x9=1.
REQ-037 Fill x1..x31 nonzero, pulse clr_req -> clr_busy high 31 cycles, all reads 0 after, writes during CLEAR dropped.
REQ-038 Assert rst at clear cycle 10 -> clr_busy=0, all registers 0, pend=0 immediately.
